// File: rtl/booth_radix4_sequential_multiplier.sv
// Iterative radix-4 Booth multiplier: one recoded digit per clock, WIDTH/2+1 digits per product.
// Signed/unsigned mode, valid/ready on both sides, synchronous flush.
module booth_radix4_sequential_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);
    localparam int N  = WIDTH / 2 + 1;
    localparam int EW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 4;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [AW-1:0] acc;
    logic [AW-1:0] a_sh;   // multiplicand pre-scaled by 4^i
    logic [EW:0]   b_sh;   // extended multiplier with B[-1]=0 appended, consumed two bits per cycle
    logic [CW-1:0] cnt;

    logic [EW-1:0] a_ext, b_ext;
    logic [AW-1:0] pp, acc_nxt;

    always_comb begin
        a_ext = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
        b_ext = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
    end

    always_comb begin
        pp = '0;
        case (b_sh[2:0])
            3'b001, 3'b010: pp = a_sh;
            3'b011:         pp = a_sh << 1;
            3'b100:         pp = -(a_sh << 1);
            3'b101, 3'b110: pp = -a_sh;
            default:        pp = '0;
        endcase
        acc_nxt = acc + pp;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            acc       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
        end else if (flush) begin
            // product deliberately keeps its last value
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh     <= {{(AW-EW){a_ext[EW-1]}}, a_ext};
                    b_sh     <= {b_ext, 1'b0};
                    acc      <= '0;
                    cnt      <= '0;
                    state    <= BUSY;
                    in_ready <= 1'b0;
                end
                BUSY: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh << 2;
                    b_sh <= {2'b00, b_sh[EW:2]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        product   <= acc_nxt[2*WIDTH-1:0];
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_radix4_sequential_multiplier.sv
// Scoreboard bench: WIDTH=32 instance for directed/random checks, WIDTH=8 instance for sweeps with stalls.
module tb_booth_radix4_sequential_multiplier;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic clr_n;

    logic        iv32, ir32, sm32, fl32, ov32, or32;
    logic [31:0] a32, b32;
    logic [63:0] p32;
    logic        iv8, ir8, sm8, fl8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] q32[$];
    logic [15:0] q8[$];

    booth_radix4_sequential_multiplier #(.WIDTH(32)) u_dut32 (
        .clk(clk), .clr_n(clr_n), .in_valid(iv32), .in_ready(ir32), .signed_mode(sm32),
        .multiplicand(a32), .multiplier(b32), .flush(fl32), .out_valid(ov32),
        .out_ready(or32), .product(p32));

    booth_radix4_sequential_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .clr_n(clr_n), .in_valid(iv8), .in_ready(ir8), .signed_mode(sm8),
        .multiplicand(a8), .multiplier(b8), .flush(fl8), .out_valid(ov8),
        .out_ready(or8), .product(p8));

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic signed [15:0] sa, sb;
        if (s) begin
            sa = {{8{a[7]}}, a};
            sb = {{8{b[7]}}, b};
            return sa * sb;
        end
        return {8'b0, a} * {8'b0, b};
    endfunction

    // Called at #1 after an edge with the DUT idle; returns the product and accept-to-valid latency.
    task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [63:0] got, output int lat);
        a32 = a; b32 = b; sm32 = s; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 100) begin
            a32 = $urandom; b32 = $urandom; sm32 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        got = p32;
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s, input int stall,
                          output logic [15:0] got, output int lat);
        a8 = a; b8 = b; sm8 = s; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin
            a8 = 8'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        repeat (stall) begin @(posedge clk); #1; end
        got = p8;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    task automatic test_reset;
        clr_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) clr_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if ({ir32, ov32, p32} !== {1'b1, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL reset32: in_ready=%b out_valid=%b product=%h, want 1 0 0", ir32, ov32, p32);
        end
        n_chk++;
        if ({ir8, ov8, p8} !== {1'b1, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset8: in_ready=%b out_valid=%b product=%h, want 1 0 0", ir8, ov8, p8);
        end
    endtask

    task automatic test_latency;
        logic [63:0] got, exp; int lat;
        q32.push_back(64'hFFFF_FFFF_FFFF_FFEB);
        do_op32(32'd7, 32'hFFFF_FFFD, 1'b1, got, lat);
        exp = q32.pop_front();
        n_chk++;
        if (lat !== 17) begin n_fail++; $display("FAIL latency: got %0d cycles, want 17", lat); end
        n_chk++;
        if (got !== exp) begin n_fail++; $display("FAIL 7x-3: got %h want %h", got, exp); end
    endtask

    task automatic test_corners;
        logic [31:0] ca[5] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] cb[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic        cs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] ce[5] = '{64'h4000_0000_0000_0000, 64'h0000_0000_8000_0000, 64'h1,
                               64'hFFFF_FFFE_0000_0001, 64'h7FFF_FFFF_8000_0000};
        logic [63:0] got, exp; int lat;
        for (int i = 0; i < 5; i++) begin
            q32.push_back(ce[i]);
            do_op32(ca[i], cb[i], cs[i], got, lat);
            exp = q32.pop_front();
            n_chk++;
            if (got !== exp || lat !== 17) begin
                n_fail++;
                $display("FAIL corner%0d: got %h lat %0d, want %h lat 17", i, got, lat, exp);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [63:0] held, exp; int lat;
        q32.push_back(ref32(32'h1234_5678, 32'h9ABC_DEF0, 1'b1));
        a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; sm32 = 1'b1; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 100) begin @(posedge clk); #1; lat++; end
        held = p32;
        for (int c = 0; c < 5; c++) begin
            iv32 = 1'b1; a32 = $urandom; b32 = $urandom;
            @(posedge clk); #1;
            n_chk++;
            if (ov32 !== 1'b1 || p32 !== held || ir32 !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: out_valid=%b in_ready=%b product=%h, want 1 0 %h", c, ov32, ir32, p32, held);
            end
        end
        iv32 = 1'b0; or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
        exp = q32.pop_front();
        n_chk++;
        if (held !== exp) begin n_fail++; $display("FAIL bp_product: got %h want %h", held, exp); end
        @(posedge clk); #1;
        n_chk++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_accept: in_ready=%b out_valid=%b, want 1 0", ir32, ov32);
        end
    endtask

    task automatic test_flush;
        logic [63:0] got, exp; int lat; bit seen;
        a32 = 32'h0000_1234; b32 = 32'h0000_5678; sm32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        fl32 = 1'b1; iv32 = 1'b1;
        @(posedge clk); #1;
        fl32 = 1'b0; iv32 = 1'b0;
        n_chk++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: in_ready=%b out_valid=%b, want 1 0", ir32, ov32);
        end
        // flush together with in_valid in IDLE must not accept
        fl32 = 1'b1; iv32 = 1'b1;
        @(posedge clk); #1;
        fl32 = 1'b0; iv32 = 1'b0;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (ov32 || !ir32) seen = 1;
            @(posedge clk); #1;
        end
        n_chk++;
        if (seen) begin n_fail++; $display("FAIL flush_quiet: out_valid rose or in_ready fell after flush, want idle"); end
        // flush in DONE drops the pending result
        a32 = 32'd9; b32 = 32'd9; sm32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 100) begin @(posedge clk); #1; lat++; end
        fl32 = 1'b1;
        @(posedge clk); #1;
        fl32 = 1'b0;
        n_chk++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1 || lat !== 17) begin
            n_fail++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b lat=%0d, want 0 1 17", ov32, ir32, lat);
        end
        q32.push_back(64'd15);
        do_op32(32'd3, 32'd5, 1'b0, got, lat);
        exp = q32.pop_front();
        n_chk++;
        if (got !== exp || lat !== 17) begin
            n_fail++;
            $display("FAIL after_flush: got %h lat %0d, want %h lat 17", got, lat, exp);
        end
    endtask

    task automatic test_async_reset;
        logic [63:0] got, exp; int lat;
        a32 = 32'hDEAD_BEEF; b32 = 32'h0BAD_F00D; sm32 = 1'b1; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #1 clr_n = 1'b0;
        #1;
        n_chk++;
        if ({ir32, ov32, p32} !== {1'b1, 1'b0, 64'h0}) begin
            n_fail++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b product=%h, want 1 0 0", ir32, ov32, p32);
        end
        @(negedge clk) clr_n = 1'b1;
        @(posedge clk); #1;
        q32.push_back(ref32(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1));
        do_op32(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, got, lat);
        exp = q32.pop_front();
        n_chk++;
        if (got !== exp || lat !== 17) begin
            n_fail++;
            $display("FAIL post_reset_op: got %h lat %0d, want %h lat 17", got, lat, exp);
        end
    endtask

    task automatic test_random32;
        logic [63:0] got, exp; logic [31:0] a, b; int lat;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 300; k++) begin
                a = $urandom; b = $urandom;
                q32.push_back(ref32(a, b, 1'(m)));
                do_op32(a, b, 1'(m), got, lat);
                exp = q32.pop_front();
                n_chk++;
                if (got !== exp || lat !== 17) begin
                    n_fail++;
                    $display("FAIL rand32 m=%0d %h*%h: got %h lat %0d, want %h lat 17", m, a, b, got, lat, exp);
                end
            end
        end
    endtask

    task automatic test_w8;
        logic [7:0] bl[5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        logic [15:0] got, exp; logic [7:0] a, b; int lat;
        for (int m = 0; m < 2; m++) begin
            for (int j = 0; j < 5; j++) begin
                for (int i = 0; i < 256; i++) begin
                    a = 8'(i);
                    q8.push_back(ref8(a, bl[j], 1'(m)));
                    do_op8(a, bl[j], 1'(m), 0, got, lat);
                    exp = q8.pop_front();
                    n_chk++;
                    if (got !== exp || lat !== 5) begin
                        n_fail++;
                        $display("FAIL sweep8 m=%0d %h*%h: got %h lat %0d, want %h lat 5", m, a, bl[j], got, lat, exp);
                    end
                end
            end
            for (int k = 0; k < 600; k++) begin
                a = 8'($urandom); b = 8'($urandom);
                q8.push_back(ref8(a, b, 1'(m)));
                do_op8(a, b, 1'(m), $urandom_range(0, 3), got, lat);
                exp = q8.pop_front();
                n_chk++;
                if (got !== exp || lat !== 5) begin
                    n_fail++;
                    $display("FAIL rand8 m=%0d %h*%h: got %h lat %0d, want %h lat 5", m, a, b, got, lat, exp);
                end
            end
        end
    endtask

    initial begin
        clr_n = 1'b0;
        iv32 = 0; sm32 = 0; fl32 = 0; or32 = 0; a32 = '0; b32 = '0;
        iv8 = 0; sm8 = 0; fl8 = 0; or8 = 0; a8 = '0; b8 = '0;
        test_reset();
        test_latency();
        test_corners();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random32();
        test_w8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
